// File: rtl/armleocpu_mem_1rw_cell.sv
// Single-port, read-first synchronous RAM cell with a registered read port.
// One word of WIDTH bits per address; byte lanes are built by instantiating
// one cell per lane. Memory contents are never reset; only readdata is.
// Optional simulation checks are compiled in when ARMLEOCPU_MEM_1RW_CHECKS_EN
// is defined; without it the block contains no check logic.
module armleocpu_mem_1rw_cell #(
  parameter int unsigned ELEMENTS_W = 7,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ELEMENTS_W-1:0] address,
  input  logic                  read,
  output logic [WIDTH-1:0]      readdata,
  input  logic                  write,
  input  logic [WIDTH-1:0]      writedata
);

  localparam int unsigned ELEMENTS = 2 ** ELEMENTS_W;

  logic [WIDTH-1:0] mem [ELEMENTS];
  logic [WIDTH-1:0] readdata_d;
  logic [WIDTH-1:0] readdata_q;

  // Next read result: load the addressed word on a read, otherwise hold.
  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      readdata_d = mem[address];
    end
  end

  // Read register; reset clears it and suppresses the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  // Array write without reset so the array maps onto block RAM; the
  // non-blocking update gives read-first behaviour on a simultaneous access.
  always_ff @(posedge clk) begin
    if (!rst && write) begin
      mem[address] <= writedata;
    end
  end

  assign readdata = readdata_q;

`ifdef ARMLEOCPU_MEM_1RW_CHECKS_EN
  // Parameter sanity at elaboration/start of simulation.
  initial begin
    if (ELEMENTS_W < 1 || WIDTH < 1) begin
      $fatal(1, "armleocpu_mem_1rw_cell: bad parameters ELEMENTS_W=%0d WIDTH=%0d",
             ELEMENTS_W, WIDTH);
    end
  end

  // Control and address must be known whenever the cell is out of reset.
  always @(posedge clk) begin
    if (!rst) begin
      if ($isunknown(read) || $isunknown(write)) begin
        $fatal(1, "armleocpu_mem_1rw_cell: read/write is X/Z");
      end
      if ((read || write) && $isunknown(address)) begin
        $fatal(1, "armleocpu_mem_1rw_cell: address is X/Z on access");
      end
    end
  end
`endif

endmodule

// File: tb/tb_armleocpu_mem_1rw_cell.sv
// Scoreboard bench: a sampler records the expected readdata after every edge
// from a word-array reference model; a monitor pops and compares after the edge.
module tb_armleocpu_mem_1rw_cell;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          read;
  logic [DW-1:0] readdata;
  logic          write;
  logic [DW-1:0] writedata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] val;
    bit            known;
  } exp_t;

  exp_t sb[$];

  // Reference model: plain word array plus written flags.
  logic [DW-1:0] ref_mem   [N];
  bit            ref_valid [N];
  logic [DW-1:0] exp_rd    = '0;
  bit            exp_known = 1'b0;
  bit            done      = 1'b0;

  armleocpu_mem_1rw_cell #(
    .ELEMENTS_W(AW),
    .WIDTH     (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .read     (read),
    .readdata (readdata),
    .write    (write),
    .writedata(writedata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] want);
    checks++;
    if (readdata !== want) begin
      errors++;
      $display("FAIL %s: readdata=%h expected %h at %0t", name, readdata, want, $time);
    end
  endtask

  // Sampler: compute what readdata must be after this edge, then update model.
  initial begin
    for (int i = 0; i < N; i++) ref_valid[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_rd    = '0;
        exp_known = 1'b1;
      end else begin
        if (read) begin
          exp_rd    = ref_mem[address];
          exp_known = ref_valid[address];
        end
        if (write) begin
          ref_mem[address]   = writedata;
          ref_valid[address] = 1'b1;
        end
      end
      sb.push_back('{val: exp_rd, known: exp_known});
    end
  end

  // Monitor: one expectation per edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.known) chk("scoreboard", e.val);
      end
    end
  end

  // One clock cycle of stimulus; returns 2 time units after the edge.
  task automatic cyc(input bit r_rst, input bit r_rd, input bit r_wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst       = r_rst;
    read      = r_rd;
    write     = r_wr;
    address   = a;
    writedata = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst       = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = '0;
    writedata = '0;

    // Reset with read requested, then idle.
    cyc(1'b1, 1'b1, 1'b0, 7'd5, '0);
    cyc(1'b1, 1'b1, 1'b0, 7'd5, '0);
    chk("reset_clears", 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_reset_idle", 32'h0);
    end

    // Write then read.
    cyc(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    chk("write_only_holds_zero", 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 7'd5, '0);
    chk("read_after_write", 32'hDEADBEEF);

    // Hold across write-only cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 7'd5, 32'h12345678);
      chk("hold_on_write", 32'hDEADBEEF);
    end

    // Read-first on simultaneous access.
    cyc(1'b0, 1'b0, 1'b1, 7'd9, 32'h11111111);
    cyc(1'b0, 1'b1, 1'b1, 7'd9, 32'h22222222);
    chk("read_first_old", 32'h11111111);
    cyc(1'b0, 1'b1, 1'b0, 7'd9, '0);
    chk("read_first_new", 32'h22222222);

    // Address boundaries.
    cyc(1'b0, 1'b0, 1'b1, 7'd0, 32'hA5A5A5A5);
    cyc(1'b0, 1'b0, 1'b1, 7'd127, 32'h5A5A5A5A);
    cyc(1'b0, 1'b1, 1'b0, 7'd0, '0);
    chk("addr_low", 32'hA5A5A5A5);
    cyc(1'b0, 1'b1, 1'b0, 7'd127, '0);
    chk("addr_high", 32'h5A5A5A5A);

    // Reset in the middle of traffic blocks the write.
    cyc(1'b0, 1'b0, 1'b1, 7'd3, 32'hCAFEF00D);
    cyc(1'b0, 1'b1, 1'b0, 7'd3, '0);
    chk("pre_reset_read", 32'hCAFEF00D);
    cyc(1'b1, 1'b1, 1'b1, 7'd3, 32'h0);
    chk("mid_reset_clears", 32'h0);
    idle();
    chk("mid_reset_release", 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 7'd3, '0);
    chk("write_ignored_in_reset", 32'hCAFEF00D);

    // Random traffic against the model; small address window to get hits.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, N - 1))
                                      : AW'($urandom_range(0, 7));
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, a, DW'($urandom));
    end

    idle();
    idle();
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: stimulus did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
    end
  end

endmodule
